// File: rtl/mul_pipe_pkg.sv
// Shared constants and operation encodings for the pipelined multiplier.
// The op decode lives here so every stage agrees on which product half is selected.
package mul_pipe_pkg;

    localparam int WORD          = 32;
    localparam int TAG_W_DEFAULT = 5;
    localparam int STAGES        = 3;

    typedef enum logic [1:0] {
        MUL_LO  = 2'b00,
        MULH_S  = 2'b01,
        MULH_U  = 2'b10,
        MUL_RSV = 2'b11
    } op_e;

    // The reserved encoding behaves exactly like a low-half multiply.
    function automatic op_e decode_op(input logic [1:0] raw);
        case (raw)
            2'b01:   return MULH_S;
            2'b10:   return MULH_U;
            default: return MUL_LO;
        endcase
    endfunction

    function automatic logic is_high_half(input op_e op);
        return (op == MULH_S) || (op == MULH_U);
    endfunction

endpackage

// File: rtl/mul_pipe_if.sv
// Request/response bundle of the pipelined multiplier.
// The slave modport is the multiplier's view, the master modport is the requester's.
interface mul_pipe_if #(
    parameter int WIDTH = mul_pipe_pkg::WORD,
    parameter int TAG_W = mul_pipe_pkg::TAG_W_DEFAULT
);

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] src0;
    logic [WIDTH-1:0] src1;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, op, src0, src1, in_tag, flush, out_ready,
        input  in_ready, out_valid, result, out_tag
    );

    modport slave (
        input  in_valid, op, src0, src1, in_tag, flush, out_ready,
        output in_ready, out_valid, result, out_tag
    );

endinterface

// File: rtl/mul_pp.sv
// Partial-product generator: operand magnitudes split into halves and
// multiplied pairwise, plus the sign of the final product for signed ops.
module mul_pp #(
    parameter int WIDTH = 32
) (
    input  logic             signed_i,
    input  logic [WIDTH-1:0] src0_i,
    input  logic [WIDTH-1:0] src1_i,
    output logic             neg_o,
    output logic [WIDTH-1:0] pp_ll_o,
    output logic [WIDTH-1:0] pp_lh_o,
    output logic [WIDTH-1:0] pp_hl_o,
    output logic [WIDTH-1:0] pp_hh_o
);

    localparam int HALF = WIDTH / 2;

    logic [WIDTH-1:0] mag0;
    logic [WIDTH-1:0] mag1;
    logic [HALF-1:0]  a_lo, a_hi, b_lo, b_hi;

    function automatic logic [WIDTH-1:0] umul(input logic [HALF-1:0] x, input logic [HALF-1:0] y);
        return {{HALF{1'b0}}, x} * {{HALF{1'b0}}, y};
    endfunction

    // The most negative value negates to itself, which is its correct unsigned magnitude.
    always_comb begin
        mag0 = (signed_i && src0_i[WIDTH-1]) ? -src0_i : src0_i;
        mag1 = (signed_i && src1_i[WIDTH-1]) ? -src1_i : src1_i;
    end

    assign neg_o = signed_i & (src0_i[WIDTH-1] ^ src1_i[WIDTH-1]);

    assign a_lo = mag0[HALF-1:0];
    assign a_hi = mag0[WIDTH-1:HALF];
    assign b_lo = mag1[HALF-1:0];
    assign b_hi = mag1[WIDTH-1:HALF];

    assign pp_ll_o = umul(a_lo, b_lo);
    assign pp_lh_o = umul(a_lo, b_hi);
    assign pp_hl_o = umul(a_hi, b_lo);
    assign pp_hh_o = umul(a_hi, b_hi);

endmodule

// File: rtl/mul_pipe.sv
// Three-stage pipelined multiplier: S0 partial products, S1 reduction,
// S2 sign fix and half select, with a single global stall and flush.
module mul_pipe
    import mul_pipe_pkg::*;
#(
    parameter int WIDTH = WORD,
    parameter int TAG_W = TAG_W_DEFAULT
) (
    input logic       clk,
    input logic       rst,
    mul_pipe_if.slave bus
);

    localparam int HALF = WIDTH / 2;

    op_e              op_in;
    logic             advance;
    logic             pp_neg;
    logic [WIDTH-1:0] pp_ll, pp_lh, pp_hl, pp_hh;

    logic             s0_valid_q, s0_valid_d;
    op_e              s0_op_q;
    logic             s0_neg_q;
    logic [TAG_W-1:0] s0_tag_q;
    logic [WIDTH-1:0] s0_ll_q, s0_lh_q, s0_hl_q, s0_hh_q;

    logic               s1_valid_q, s1_valid_d;
    op_e                s1_op_q;
    logic               s1_neg_q;
    logic [TAG_W-1:0]   s1_tag_q;
    logic [2*WIDTH-1:0] s1_mag_q, s1_mag_d;

    logic               s2_valid_q, s2_valid_d;
    logic [2*WIDTH-1:0] s2_full;
    logic [WIDTH-1:0]   s2_result_q, s2_result_d;
    logic [TAG_W-1:0]   s2_tag_q;

    assign op_in   = decode_op(bus.op);
    assign advance = !s2_valid_q || bus.out_ready;

    mul_pp #(
        .WIDTH(WIDTH)
    ) u_pp (
        .signed_i(op_in == MULH_S),
        .src0_i  (bus.src0),
        .src1_i  (bus.src1),
        .neg_o   (pp_neg),
        .pp_ll_o (pp_ll),
        .pp_lh_o (pp_lh),
        .pp_hl_o (pp_hl),
        .pp_hh_o (pp_hh)
    );

    // Flush wins over both stall and a request offered in the same cycle.
    always_comb begin
        s0_valid_d = s0_valid_q;
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (bus.flush) begin
            s0_valid_d = 1'b0;
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else if (advance) begin
            s0_valid_d = bus.in_valid;
            s1_valid_d = s0_valid_q;
            s2_valid_d = s1_valid_q;
        end
    end

    always_comb begin
        s1_mag_d = {s0_hh_q, s0_ll_q}
                 + {{HALF{1'b0}}, s0_lh_q, {HALF{1'b0}}}
                 + {{HALF{1'b0}}, s0_hl_q, {HALF{1'b0}}};
    end

    always_comb begin
        s2_full     = s1_neg_q ? -s1_mag_q : s1_mag_q;
        s2_result_d = is_high_half(s1_op_q) ? s2_full[2*WIDTH-1:WIDTH] : s2_full[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_tag_q    <= '0;
        end else begin
            s0_valid_q <= s0_valid_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (advance && s1_valid_q) begin
                s2_result_q <= s2_result_d;
                s2_tag_q    <= s1_tag_q;
            end
        end
    end

    // Payload registers need no reset: they are only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (advance) begin
            s0_op_q  <= op_in;
            s0_neg_q <= pp_neg;
            s0_tag_q <= bus.in_tag;
            s0_ll_q  <= pp_ll;
            s0_lh_q  <= pp_lh;
            s0_hl_q  <= pp_hl;
            s0_hh_q  <= pp_hh;
            s1_op_q  <= s0_op_q;
            s1_neg_q <= s0_neg_q;
            s1_tag_q <= s0_tag_q;
            s1_mag_q <= s1_mag_d;
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = s2_valid_q;
    assign bus.result    = s2_result_q;
    assign bus.out_tag   = s2_tag_q;

endmodule

// File: tb/tb_mul_pipe.sv
// Scoreboard bench for mul_pipe at WIDTH=32 and WIDTH=16: directed corner
// cases (latency, stall, flush, reset) followed by randomized traffic.
module tb_mul_pipe;
    import mul_pipe_pkg::*;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   readyMode = 0;
    exp_t q32[$];
    exp_t q16[$];

    mul_pipe_if #(.WIDTH(32), .TAG_W(5)) bus32 ();
    mul_pipe_if #(.WIDTH(16), .TAG_W(5)) bus16 ();

    mul_pipe #(.WIDTH(32), .TAG_W(5)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
    mul_pipe #(.WIDTH(16), .TAG_W(5)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Full product from plain 64-bit arithmetic, then pick the requested half.
    function automatic logic [31:0] refModel(input int w, input logic [1:0] op,
                                             input logic [31:0] a, input logic [31:0] b);
        longint unsigned mask, ua, ub, full;
        longint          sa, sb;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        sa   = $signed(ua << (64 - w)) >>> (64 - w);
        sb   = $signed(ub << (64 - w)) >>> (64 - w);
        if (op == 2'b01) full = sa * sb;
        else             full = ua * ub;
        if (op == 2'b01 || op == 2'b10) full = full >> w;
        return 32'(full & mask);
    endfunction

    function automatic logic [31:0] pickOperand(input int w);
        logic [31:0] mask;
        logic [31:0] minNeg;
        mask   = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        minNeg = 32'h1 << (w - 1);
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return mask;
            3:       return minNeg;
            4:       return minNeg - 32'd1;
            default: return $urandom() & mask;
        endcase
    endfunction

    // Holds a request until accepted; a flush request is never accepted and empties the scoreboard.
    task automatic applyStimulus(input bit wide, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] tag, input bit doFlush,
                                 input bit hasExp, input logic [31:0] expv);
        exp_t e;
        bit   done;
        int   waited;
        logic rdy;
        done     = 1'b0;
        waited   = 0;
        e.tag    = tag;
        e.result = hasExp ? expv : refModel(wide ? 32 : 16, op, a, b);
        if (wide) begin
            bus32.in_valid = 1'b1; bus32.op = op; bus32.src0 = a; bus32.src1 = b;
            bus32.in_tag = tag; bus32.flush = doFlush;
        end else begin
            bus16.in_valid = 1'b1; bus16.op = op; bus16.src0 = a[15:0]; bus16.src1 = b[15:0];
            bus16.in_tag = tag; bus16.flush = doFlush;
        end
        while (!done) begin
            @(negedge clk);
            rdy = wide ? bus32.in_ready : bus16.in_ready;
            if (doFlush) begin
                if (wide) q32.delete(); else q16.delete();
                done = 1'b1;
            end else if (rdy) begin
                if (wide) q32.push_back(e); else q16.push_back(e);
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 100) begin
                    checkOutput("accept_timeout", 32'd0, 32'd1);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        if (wide) begin bus32.in_valid = 1'b0; bus32.flush = 1'b0; end
        else      begin bus16.in_valid = 1'b0; bus16.flush = 1'b0; end
    endtask

    task automatic randomOne(input bit wide, input int idx);
        int w;
        w = wide ? 32 : 16;
        if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
        end
        applyStimulus(wide, 2'($urandom_range(0, 3)), pickOperand(w), pickOperand(w), 5'(idx), 1'b0, 1'b0, 32'd0);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((q32.size() != 0 || q16.size() != 0) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_w32", 32'(q32.size()), 32'd0);
        checkOutput("drain_w16", 32'(q16.size()), 32'd0);
    endtask

    // Monitor: every handshake on either output is compared with the oldest expectation.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && bus32.out_valid && bus32.out_ready) begin
            if (q32.size() == 0) checkOutput("w32_unexpected_output", 32'd1, 32'd0);
            else begin
                e = q32.pop_front();
                checkOutput("w32_result", bus32.result, e.result);
                checkOutput("w32_tag", {27'd0, bus32.out_tag}, {27'd0, e.tag});
            end
        end
        if (!rst && bus16.out_valid && bus16.out_ready) begin
            if (q16.size() == 0) checkOutput("w16_unexpected_output", 32'd1, 32'd0);
            else begin
                e = q16.pop_front();
                checkOutput("w16_result", {16'd0, bus16.result}, e.result);
                checkOutput("w16_tag", {27'd0, bus16.out_tag}, {27'd0, e.tag});
            end
        end
    end

    // Consumer: always ready, fully stalled, or randomly ready.
    initial begin
        bus32.out_ready = 1'b1;
        bus16.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (readyMode)
                0: begin bus32.out_ready = 1'b1; bus16.out_ready = 1'b1; end
                1: begin bus32.out_ready = 1'b0; bus16.out_ready = 1'b0; end
                default: begin
                    bus32.out_ready = ($urandom_range(0, 3) != 0);
                    bus16.out_ready = ($urandom_range(0, 3) != 0);
                end
            endcase
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a1, b1, exp1;
        int          edges;
        bit          seen;

        rst = 1'b1;
        bus32.in_valid = 1'b0; bus32.op = 2'b00; bus32.src0 = '0; bus32.src1 = '0;
        bus32.in_tag = '0; bus32.flush = 1'b0;
        bus16.in_valid = 1'b0; bus16.op = 2'b00; bus16.src0 = '0; bus16.src1 = '0;
        bus16.in_tag = '0; bus16.flush = 1'b0;
        #1;
        checkOutput("reset_out_valid", {31'd0, bus32.out_valid}, 32'd0);
        checkOutput("reset_result", bus32.result, 32'd0);
        checkOutput("reset_out_tag", {27'd0, bus32.out_tag}, 32'd0);
        checkOutput("reset_in_ready", {31'd0, bus32.in_ready}, 32'd1);
        checkOutput("reset_w16_out_valid", {31'd0, bus16.out_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Latency from the accepting edge to out_valid.
        applyStimulus(1'b1, 2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 5'd0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        edges = 1;
        seen  = 1'b0;
        while (!seen && edges < 20) begin
            @(negedge clk);
            if (bus32.out_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
                edges++;
            end
        end
        checkOutput("latency_edges", 32'(edges), 32'(STAGES));
        checkOutput("latency_result", bus32.result, 32'hFFFF_FFFE);
        @(posedge clk);
        #1;

        applyStimulus(1'b1, 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 5'd1, 1'b0, 1'b1, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 5'd2, 1'b0, 1'b1, 32'h0000_0001);
        applyStimulus(1'b1, 2'b01, 32'h8000_0000, 32'h8000_0000, 5'd3, 1'b0, 1'b1, 32'h4000_0000);
        applyStimulus(1'b1, 2'b00, 32'h8000_0000, 32'h8000_0000, 5'd4, 1'b0, 1'b1, 32'h0000_0000);
        applyStimulus(1'b1, 2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 5'd5, 1'b0, 1'b1, 32'hFFFF_FFFE);
        applyStimulus(1'b1, 2'b01, 32'h8000_0000, 32'h7FFF_FFFF, 5'd6, 1'b0, 1'b1, 32'hC000_0000);
        applyStimulus(1'b0, 2'b01, 32'h0000_8000, 32'h0000_8000, 5'd7, 1'b0, 1'b1, 32'h0000_4000);
        applyStimulus(1'b0, 2'b01, 32'h0000_FFFF, 32'h0000_0002, 5'd8, 1'b0, 1'b1, 32'h0000_FFFF);
        waitDrain();

        // Backpressure: fill the pipe with the consumer stalled, then release.
        readyMode = 1;
        a1   = 32'h1234_5678;
        b1   = 32'h9ABC_DEF0;
        exp1 = refModel(32, 2'b00, a1, b1);
        applyStimulus(1'b1, 2'b00, a1, b1, 5'd1, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 2'b10, 32'hDEAD_BEEF, 32'h0000_1003, 5'd2, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 2'b01, 32'hFFFF_FF00, 32'h0000_0100, 5'd3, 1'b0, 1'b0, 32'd0);
        bus32.in_valid = 1'b1; bus32.op = 2'b01; bus32.src0 = 32'h8000_0000;
        bus32.src1 = 32'hFFFF_FFFF; bus32.in_tag = 5'd4;
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall_in_ready", {31'd0, bus32.in_ready}, 32'd0);
            checkOutput("stall_out_tag", {27'd0, bus32.out_tag}, 32'd1);
            checkOutput("stall_result", bus32.result, exp1);
            @(posedge clk);
            #1;
        end
        readyMode = 0;
        applyStimulus(1'b1, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 1'b0, 1'b0, 32'd0);
        waitDrain();

        // Flush kills tags 7 and 8 and the request offered alongside it.
        applyStimulus(1'b1, 2'b00, 32'd7, 32'd11, 5'd7, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 2'b00, 32'd8, 32'd13, 5'd8, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 2'b00, 32'd6, 32'd6, 5'd6, 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, 2'b00, 32'd9, 32'd9, 5'd9, 1'b0, 1'b1, 32'd81);
        repeat (2) begin
            @(negedge clk);
            checkOutput("flush_out_valid", {31'd0, bus32.out_valid}, 32'd0);
            @(posedge clk);
            #1;
        end
        waitDrain();

        // Reset with three operations in flight.
        applyStimulus(1'b1, 2'b00, 32'h0001_0003, 32'h0000_0005, 5'd10, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 2'b00, 32'h0002_0003, 32'h0000_0007, 5'd11, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 2'b00, 32'h0003_0003, 32'h0000_0009, 5'd12, 1'b0, 1'b0, 32'd0);
        #1;
        rst = 1'b1;
        q32.delete();
        q16.delete();
        #1;
        checkOutput("midreset_out_valid", {31'd0, bus32.out_valid}, 32'd0);
        checkOutput("midreset_result", bus32.result, 32'd0);
        checkOutput("midreset_out_tag", {27'd0, bus32.out_tag}, 32'd0);
        checkOutput("midreset_in_ready", {31'd0, bus32.in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("postreset_out_valid", {31'd0, bus32.out_valid}, 32'd0);
            checkOutput("postreset_in_ready", {31'd0, bus32.in_ready}, 32'd1);
            @(posedge clk);
            #1;
        end

        // Randomized traffic on both widths with a randomly stalling consumer.
        readyMode = 2;
        fork
            for (int i = 0; i < 250; i++) randomOne(1'b1, i);
            for (int j = 0; j < 250; j++) randomOne(1'b0, j);
        join
        readyMode = 0;
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
